// File: rtl/tone_sequencer.sv
`default_nettype none
// ==========================================================================
// tone_sequencer : song-ROM note sequencer with live-keyboard override.
// Optional macro TONE_SEQUENCER_LOOP_EN repeats the song until stop/reset.
// Revision: 1.0
// ==========================================================================
module tone_sequencer #(
  parameter int unsigned BEAT_CYC = 12500000,
  parameter int unsigned GAP_CYC  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       stop,
  input  logic       live_on,
  input  logic [4:0] live_key,
  output logic [5:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic       key_on,
  output logic [4:0] key,
  output logic       busy,
  output logic       song_done
);

  localparam logic [31:0] C_BEAT = 32'(BEAT_CYC);
  localparam logic [31:0] C_GAP  = 32'(GAP_CYC);
  localparam logic [5:0]  C_LAST = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_NOTE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  rom_addr_q, rom_addr_d;
  logic        seq_on_q, seq_on_d;
  logic [4:0]  seq_key_q, seq_key_d;
  logic        key_on_q, key_on_d;
  logic [4:0]  key_q, key_d;
  logic        busy_q, busy_d;
  logic        song_done_q, song_done_d;
  logic        song_end;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    seq_on_d    = seq_on_q;
    seq_key_d   = seq_key_q;
    song_done_d = 1'b0;
    song_end    = 1'b0;

    // The sequencer is frozen in place while the live keyboard owns the outputs.
    if (!live_on) begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            state_d    = S_FETCH;
            idx_d      = '0;
            rom_addr_d = '0;
          end
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          if (rom_data[8]) begin
            song_end = 1'b1;
          end else begin
            state_d   = S_NOTE;
            cnt_d     = ({29'd0, rom_data[2:0]} + 32'd1) * C_BEAT;
            seq_on_d  = ~rom_data[7];
            seq_key_d = rom_data[7] ? 5'd0 : rom_data[7:3];
          end
        end
        S_NOTE: begin
          if (cnt_q <= 32'd1) begin
            state_d   = S_GAP;
            cnt_d     = C_GAP;
            seq_on_d  = 1'b0;
            seq_key_d = 5'd0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_GAP: begin
          if (cnt_q <= 32'd1) begin
            if (idx_q == C_LAST) begin
              song_end = 1'b1;
            end else begin
              state_d    = S_FETCH;
              idx_d      = idx_q + 6'd1;
              rom_addr_d = idx_q + 6'd1;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // End marker and index wrap share one termination path.
    if (song_end) begin
      song_done_d = 1'b1;
      idx_d       = '0;
      cnt_d       = '0;
`ifdef TONE_SEQUENCER_LOOP_EN
      state_d     = S_FETCH;
      rom_addr_d  = '0;
`else
      state_d     = S_IDLE;
`endif
    end

    if (stop) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      rom_addr_d  = '0;
      seq_on_d    = 1'b0;
      seq_key_d   = 5'd0;
      song_done_d = 1'b0;
    end

    busy_d   = (state_d != S_IDLE);
    key_on_d = live_on | seq_on_d;
    key_d    = live_on ? live_key : seq_key_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      seq_on_q    <= 1'b0;
      seq_key_q   <= 5'd0;
      key_on_q    <= 1'b0;
      key_q       <= 5'd0;
      busy_q      <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      seq_on_q    <= seq_on_d;
      seq_key_q   <= seq_key_d;
      key_on_q    <= key_on_d;
      key_q       <= key_d;
      busy_q      <= busy_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign key_on    = key_on_q;
  assign key       = key_q;
  assign busy      = busy_q;
  assign song_done = song_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_tone_sequencer : directed bench for tone_sequencer (BEAT_CYC=4, GAP_CYC=2).
// Revision: 1.0
// ==========================================================================
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       live_on = 1'b0;
  logic [4:0] live_key = 5'd0;
  logic [5:0] rom_addr;
  logic [8:0] rom_data;
  logic       key_on;
  logic [4:0] key;
  logic       busy;
  logic       song_done;

  logic [8:0] rom [64];
  int n_chk  = 0;
  int n_fail = 0;
  int n;

`ifdef TONE_SEQUENCER_LOOP_EN
  localparam logic [31:0] C_LOOP = 32'd1;
`else
  localparam logic [31:0] C_LOOP = 32'd0;
`endif

  tone_sequencer #(.BEAT_CYC(4), .GAP_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .play      (play),
    .stop      (stop),
    .live_on   (live_on),
    .live_key  (live_key),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .key_on    (key_on),
    .key       (key),
    .busy      (busy),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] ent(input logic e, input logic [4:0] nt, input logic [2:0] d);
    return {e, nt, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic measure_on(input logic [4:0] k, output int len);
    len = 0;
    while (key_on === 1'b1 && key === k && len < 64) begin
      len++;
      tick();
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = ent(1'b1, 5'd0, 3'd0);
  endtask

  task automatic load_song1();
    clear_rom();
    rom[0] = ent(1'b0, 5'd5, 3'd1);
  endtask

  task automatic start();
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    clear_rom();
    // Reset values
    repeat (2) tick();
    chk("rst_key_on", 32'(key_on), 32'd0);
    chk("rst_key", 32'(key), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_song_done", 32'(song_done), 32'd0);
    rst = 1'b1;
    tick();

    // Basic song: note 5 for 2 beats, then end marker
    load_song1();
    start();
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_addr0", 32'(rom_addr), 32'd0);
    tick();
    tick();
    chk("s1_key_on", 32'(key_on), 32'd1);
    chk("s1_key", 32'(key), 32'd5);
    measure_on(5'd5, n);
    chk("s1_note_len", 32'(n), 32'd8);
    chk("s1_gap1_off", 32'(key_on), 32'd0);
    tick();
    chk("s1_gap2_off", 32'(key_on), 32'd0);
    chk("s1_gap2_addr", 32'(rom_addr), 32'd0);
    tick();
    chk("s1_addr1", 32'(rom_addr), 32'd1);
    tick();
    tick();
    chk("s1_done", 32'(song_done), 32'd1);
    chk("s1_busy_end", 32'(busy), C_LOOP);
    chk("s1_addr_end", 32'(rom_addr), (C_LOOP != 0) ? 32'd0 : 32'd1);
    tick();
    chk("s1_done_pulse", 32'(song_done), 32'd0);
`ifdef TONE_SEQUENCER_LOOP_EN
    repeat (13) tick();
    chk("loop_done2", 32'(song_done), 32'd1);
    chk("loop_busy2", 32'(busy), 32'd1);
`endif
    stop_pulse();

    // Rest entry then a short note
    clear_rom();
    rom[0] = ent(1'b0, 5'd20, 3'd0);
    rom[1] = ent(1'b0, 5'd3, 3'd0);
    start();
    tick();
    tick();
    chk("s2_rest_off", 32'(key_on), 32'd0);
    chk("s2_rest_key", 32'(key), 32'd0);
    chk("s2_rest_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("s2_rest_off4", 32'(key_on), 32'd0);
    tick();
    tick();
    chk("s2_gap_addr", 32'(rom_addr), 32'd0);
    tick();
    chk("s2_fetch1", 32'(rom_addr), 32'd1);
    tick();
    tick();
    chk("s2_note3", 32'(key), 32'd3);
    measure_on(5'd3, n);
    chk("s2_note_len", 32'(n), 32'd4);
    stop_pulse();

    // Stop in the 3rd NOTE cycle; play+stop in IDLE
    load_song1();
    start();
    repeat (4) tick();
    chk("s3_on_c3", 32'(key_on), 32'd1);
    stop = 1'b1;
    tick();
    chk("s3_stop_off", 32'(key_on), 32'd0);
    chk("s3_stop_busy", 32'(busy), 32'd0);
    chk("s3_stop_nodone", 32'(song_done), 32'd0);
    play = 1'b1;
    tick();
    chk("s3_playstop_busy", 32'(busy), 32'd0);
    play = 1'b0;
    stop = 1'b0;
    tick();
    chk("s3_idle_busy", 32'(busy), 32'd0);

    // Live override for 5 cycles mid-note
    load_song1();
    start();
    repeat (3) tick();
    chk("s4_key5", 32'(key), 32'd5);
    live_on = 1'b1;
    live_key = 5'd9;
    tick();
    chk("s4_live_key", 32'(key), 32'd9);
    chk("s4_live_on", 32'(key_on), 32'd1);
    repeat (4) tick();
    chk("s4_live_key5", 32'(key), 32'd9);
    chk("s4_live_on5", 32'(key_on), 32'd1);
    live_on = 1'b0;
    tick();
    chk("s4_resume_key", 32'(key), 32'd5);
    measure_on(5'd5, n);
    chk("s4_remaining", 32'(n), 32'd6);
    stop_pulse();

    // Stop while live is active
    load_song1();
    start();
    tick();
    tick();
    live_on = 1'b1;
    live_key = 5'd9;
    stop = 1'b1;
    tick();
    chk("s4b_busy", 32'(busy), 32'd0);
    chk("s4b_live_on", 32'(key_on), 32'd1);
    chk("s4b_live_key", 32'(key), 32'd9);
    stop = 1'b0;
    live_on = 1'b0;
    tick();
    chk("s4b_after_on", 32'(key_on), 32'd0);
    chk("s4b_after_key", 32'(key), 32'd0);

    // Asynchronous reset mid-note
    load_song1();
    start();
    tick();
    tick();
    chk("s5_on", 32'(key_on), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("s5_async_on", 32'(key_on), 32'd0);
    chk("s5_async_key", 32'(key), 32'd0);
    chk("s5_async_busy", 32'(busy), 32'd0);
    chk("s5_async_addr", 32'(rom_addr), 32'd0);
    #1;
    rst = 1'b1;
    tick();
    chk("s5_idle", 32'(busy), 32'd0);

    // Index wrap: 64 entries, no end marker, 8 cycles per entry
    for (int i = 0; i < 64; i++) rom[i] = ent(1'b0, 5'd1, 3'd0);
    start();
    n = 1;
    while (song_done !== 1'b1 && n < 700) begin
      tick();
      n++;
    end
    chk("s6_wrap_edge", 32'(n), 32'd513);
    chk("s6_wrap_busy", 32'(busy), C_LOOP);
    stop_pulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYC, default 12500000: clock cycles per beat (125 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_CYC, default 2000000: silent cycles between notes (20 ms).
REQ-003 SHALL have port clk  input  1: sole clock, rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port play  input  1: start song playback (level, sampled per cycle).
REQ-006 SHALL have port stop  input  1: abort playback.
REQ-007 SHALL have port live_on  input  1: live keyboard key pressed.
REQ-008 SHALL have port live_key  input  5: live note index.
REQ-009 SHALL have port rom_addr  output  6: song ROM address.
REQ-010 SHALL have port rom_data  input  9: ROM word, valid one cycle after rom_addr. Fields: [8] end marker, [7:3] note, [2:0] duration code.
REQ-011 SHALL have port key_on  output  1: tone enable to the tone generator.
REQ-012 SHALL have port key  output  5: note index to the tone generator.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.
REQ-014 SHALL have port song_done  output  1: one-cycle pulse on normal song completion.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LATCH, NOTE, GAP; all outputs registered.
REQ-016 IDLE: play=1 and stop=0 SHALL set idx=0 and go to FETCH; play while busy SHALL be ignored.
REQ-017 FETCH: rom_addr=idx for one cycle, then LATCH.
REQ-018 LATCH: SHALL capture rom_data. End bit=1 -> IDLE with song_done pulse. Otherwise -> NOTE with dcnt=(dur+1)*BEAT_CYC.
REQ-019 NOTE: key_on=1, key=note for exactly (dur+1)*BEAT_CYC cycles, then GAP with key_on=0 for exactly GAP_CYC cycles, then idx+1 and FETCH.
REQ-020 Note value 16..31 SHALL be a rest: key_on=0 for the full duration, key held at 0.
REQ-021 Idx wrap: completing entry 63 without an end marker SHALL terminate as if an end marker were read (song_done, IDLE).
REQ-022 stop=1 in any state SHALL force IDLE on the next edge: key_on=0, no song_done. stop has priority over play in the same cycle.
REQ-023 live_on=1 SHALL override outputs the same cycle after sampling: key_on=1, key=live_key. The sequencer SHALL freeze (state, idx and counters hold) while live_on=1 and resume where it stopped when live_on falls.
REQ-024 stop with live_on=1 SHALL still reset the sequencer to IDLE; the live override continues.
REQ-025 Duration counter SHALL be at least 32 bits; no overflow for 8*BEAT_CYC.

Reset
REQ-026 rst=0 SHALL asynchronously force: IDLE, idx=0, counters=0, rom_addr=0, key_on=0, key=0, busy=0, song_done=0.
REQ-027 Reset mid-note SHALL silence key_on immediately, without waiting for a clock edge.

Configuration
REQ-028 With TONE_SEQUENCER_LOOP_EN defined, an end marker or wrap SHALL pulse song_done and continue at idx=0 in FETCH, with busy held high; only stop or reset returns to IDLE.
REQ-029 Without TONE_SEQUENCER_LOOP_EN, end marker and wrap SHALL behave per REQ-018 and REQ-021.

Verification (BEAT_CYC=4, GAP_CYC=2)
REQ-030 ROM {note 5, dur 1}, {end}; pulse play -> rom_addr=0 then 1; key_on=1, key=5 for 8 cycles; 2 silent cycles; then song_done pulse, busy=0.
REQ-031 Entry {note 20, dur 0} -> key_on=0 for 4 cycles, then 2 gap cycles, then next fetch.
REQ-032 stop asserted in the 3rd NOTE cycle -> next cycle key_on=0, busy=0, no song_done; play and stop together in IDLE -> stays IDLE.
REQ-033 live_on=1, live_key=9 for 5 cycles mid-note -> key=9, key_on=1 throughout; the original note then resumes with its remaining cycles intact.
REQ-034 rst=0 pulsed between clock edges during NOTE -> key_on=0 before the next edge; all outputs at reset values.
REQ-035 LOOP_EN build, two-entry song -> song_done pulses once per pass, rom_addr returns to 0, busy stays 1.
